// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder backing an on-chip word array with programmable latency
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lat_wen;
  logic [1:0]    lat_size;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          eff_wen;
  logic [1:0]    eff_size;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic [31:0]   off;
  logic [1:0]    lane;
  logic [IW-1:0] idx;
  logic          fault;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh;
  logic [31:0]   rd_sh;
  logic [31:0]   rd_val;

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge itself, so the live
  // request inputs feed the datapath while idle; otherwise the latched copy does.
  assign eff_wen   = (state == IDLE) ? req_wen   : lat_wen;
  assign eff_size  = (state == IDLE) ? req_size  : lat_size;
  assign eff_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign eff_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  assign enter_resp = (LATENCY == 1) ? accept : ((state == BUSY) && (cnt == CW'(1)));

  assign off  = eff_addr - BASE_ADDR;
  assign lane = eff_addr[1:0];
  assign idx  = off[IW+1:2];

  always_comb begin
    fault = 1'b0;
    if (eff_size == 2'd3) fault = 1'b1;
    if ((eff_size == 2'd1) && eff_addr[0]) fault = 1'b1;
    if ((eff_size == 2'd2) && (eff_addr[1:0] != 2'b00)) fault = 1'b1;
    // Unsigned wrap makes addresses below BASE_ADDR land far above SPAN.
    if ({1'b0, off} >= SPAN) fault = 1'b1;
  end

  always_comb begin
    wmask = 4'h0;
    case (eff_size)
      2'd0:    wmask = 4'b0001 << lane;
      2'd1:    wmask = 4'b0011 << lane;
      2'd2:    wmask = 4'b1111;
      default: wmask = 4'h0;
    endcase
  end

  assign wdata_sh = eff_wdata << {lane, 3'b000};
  assign rd_sh    = mem[idx] >> {lane, 3'b000};

  always_comb begin
    rd_val = rd_sh;
    case (eff_size)
      2'd0:    rd_val = {24'h0, rd_sh[7:0]};
      2'd1:    rd_val = {16'h0, rd_sh[15:0]};
      default: rd_val = rd_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && eff_wen && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_wen   <= req_wen;
            lat_size  <= req_size;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY != 1) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        state     <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= fault;
        rsp_rdata <= (fault || eff_wen) ? 32'h0 : rd_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at latencies 2, 3 and 1
module tb_dmem_responder;

  logic        clk;
  logic [2:0]  rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int checks;
  int failures;

  dmem_responder #(.LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic access(input int s, input logic wen, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                        input string tag);
    int n;
    req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 20) begin @(negedge clk); n++; end
    check({tag, ".ready"}, 32'(req_ready[s]), 32'd1);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_size = 2'd3;
    n = 1;
    while (!rsp_valid[s] && n < 20) begin @(negedge clk); n++; end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".rdata"}, rsp_rdata[s], exp_d);
    check({tag, ".err"}, 32'(rsp_err[s]), 32'(exp_e));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 3'b000; req_valid = 3'b000; rsp_ready = 3'b111;
    req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d.req_ready", s), 32'(req_ready[s]), 32'd1);
      check($sformatf("rst%0d.rsp_valid", s), 32'(rsp_valid[s]), 32'd0);
      check($sformatf("rst%0d.rdata", s), rsp_rdata[s], 32'h0);
      check($sformatf("rst%0d.err", s), 32'(rsp_err[s]), 32'd0);
    end

    // Latency 2: word store/load, sub-word store and loads
    access(0, 1'b1, 2'd2, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "st_w");
    access(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "ld_w");
    access(0, 1'b1, 2'd0, 32'h8000_0011, 32'hFFFF_FFAA, 32'h0, 1'b0, 2, "st_b");
    access(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, 2, "ld_w2");
    access(0, 1'b0, 2'd0, 32'h8000_0013, 32'h0, 32'h0000_00DE, 1'b0, 2, "ld_b");
    access(0, 1'b0, 2'd1, 32'h8000_0012, 32'h0, 32'h0000_DEAD, 1'b0, 2, "ld_h");

    // Faults
    access(0, 1'b0, 2'd1, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 2, "f_half");
    access(0, 1'b0, 2'd2, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 2, "f_low");
    access(0, 1'b0, 2'd3, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 2, "f_size3");
    access(0, 1'b0, 2'd2, 32'h8000_1000, 32'h0, 32'h0, 1'b1, 2, "f_high");
    access(0, 1'b1, 2'd2, 32'h8000_0012, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, "f_st_w");
    access(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'hDEAD_AAEF, 1'b0, 2, "ld_unch");
    access(0, 1'b1, 2'd2, 32'h8000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2, "st_top");
    access(0, 1'b0, 2'd2, 32'h8000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2, "ld_top");
    access(0, 1'b1, 2'd1, 32'h8000_0012, 32'h0000_1234, 32'h0, 1'b0, 2, "st_h");
    access(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h1234_AAEF, 1'b0, 2, "ld_w3");

    // Backpressure: response held, pending request must wait for the handshake
    rsp_ready[0] = 1'b0;
    req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h8000_0010; req_valid[0] = 1'b1;
    @(negedge clk);
    req_wen = 1'b1; req_wdata = 32'h5555_5555;
    check("bp.busy_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.valid", i), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp%0d.rdata", i), rsp_rdata[0], 32'h1234_AAEF);
      check($sformatf("bp%0d.err", i), 32'(rsp_err[0]), 32'd0);
      check($sformatf("bp%0d.ready", i), 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp.idle_ready", 32'(req_ready[0]), 32'd1);
    check("bp.idle_valid", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp.st_valid", 32'(rsp_valid[0]), 32'd1);
    check("bp.st_rdata", rsp_rdata[0], 32'h0);
    @(negedge clk);
    access(0, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 32'h5555_5555, 1'b0, 2, "bp_ld");

    // Latency 3: reset while a store is in BUSY drops it
    access(1, 1'b1, 2'd2, 32'h8000_0020, 32'h1111_1111, 32'h0, 1'b0, 3, "l3_st");
    req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h8000_0020; req_wdata = 32'h2222_2222;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    check("rb.valid", 32'(rsp_valid[1]), 32'd0);
    check("rb.ready", 32'(req_ready[1]), 32'd1);
    repeat (2) @(negedge clk);
    check("rb.valid_later", 32'(rsp_valid[1]), 32'd0);
    access(1, 1'b0, 2'd2, 32'h8000_0020, 32'h0, 32'h1111_1111, 1'b0, 3, "rb_ld");

    // Latency 1: back-to-back accepts every other cycle
    access(2, 1'b1, 2'd2, 32'h8000_0000, 32'h1234_5678, 32'h0, 1'b0, 1, "l1_st0");
    access(2, 1'b1, 2'd2, 32'h8000_0004, 32'h9ABC_DEF0, 32'h0, 1'b0, 1, "l1_st1");
    req_wen = 1'b0; req_size = 2'd2; req_valid[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b%0d.ready", i), 32'(req_ready[2]), 32'(i % 2 == 0));
      check($sformatf("b2b%0d.valid", i), 32'(rsp_valid[2]), 32'(i % 2 == 1));
      if (i % 2 == 0) req_addr = (i % 4 == 0) ? 32'h8000_0000 : 32'h8000_0004;
      else check($sformatf("b2b%0d.rdata", i), rsp_rdata[2],
                 (i % 4 == 1) ? 32'h1234_5678 : 32'h9ABC_DEF0);
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
